// File: rtl/satellite_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling that feeds a small AXI-Stream FIFO.
// Bad stop bits pulse frame_err; bytes arriving at a full FIFO are dropped and flagged.
module satellite_uart_rx #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_aresetn,
    input  logic                        satellite_uart_0_rxd,
    output logic [7:0]                  m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        frame_err,
    output logic                        overflow,
    input  logic                        overflow_clr,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [15:0]      BIT_RELOAD  = 16'(CLK_DIV - 1);
    localparam logic [15:0]      HALF_RELOAD = 16'(CLK_DIV / 2 - 1);
    localparam logic [LVL_W-1:0] FULL_LEVEL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    // Reset asserts immediately but releases only after two clean clock edges.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    logic [1:0] rxd_sync_q;
    logic       rxd_s;

    always_ff @(posedge s_axi_aclk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_sync_q <= 2'b11;
        end else begin
            rxd_sync_q <= {rxd_sync_q[0], satellite_uart_0_rxd};
        end
    end

    assign rxd_s = rxd_sync_q[1];

    // Receive state machine
    state_e      state_q,     state_d;
    logic [15:0] cnt_q,       cnt_d;
    logic [2:0]  bit_idx_q,   bit_idx_d;
    logic [7:0]  shift_q,     shift_d;
    logic        wait_high_q, wait_high_d;
    logic        frame_err_q;
    logic        byte_done;
    logic        stop_bad;

    always_ff @(posedge s_axi_aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            wait_high_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            wait_high_q <= wait_high_d;
            frame_err_q <= stop_bad;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        wait_high_d = wait_high_q;
        byte_done   = 1'b0;
        stop_bad    = 1'b0;

        case (state_q)
            IDLE: begin
                // After a framing error the line must be seen high before a new start bit counts.
                if (wait_high_q) begin
                    if (rxd_s) begin
                        wait_high_d = 1'b0;
                    end
                end else if (!rxd_s) begin
                    cnt_d   = HALF_RELOAD;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (rxd_s) begin
                    state_d = IDLE;
                end else begin
                    cnt_d     = BIT_RELOAD;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    shift_d   = {rxd_s, shift_q[7:1]};
                    cnt_d     = BIT_RELOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    state_d = IDLE;
                    if (rxd_s) begin
                        byte_done = 1'b1;
                    end else begin
                        stop_bad    = 1'b1;
                        wait_high_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Receive FIFO
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q;
    logic             fifo_full;
    logic             do_read;
    logic             do_write;
    logic             drop;

    assign fifo_full = (level_q == FULL_LEVEL);
    assign do_read   = m_axis_tvalid & m_axis_tready;
    assign do_write  = byte_done & (~fifo_full | do_read);
    assign drop      = byte_done & fifo_full & ~do_read;

    // NOTE: storage is not reset; the level counter alone decides which entries are valid.
    always_ff @(posedge s_axi_aclk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_comb begin
        level_d = level_q;
        if (do_write && !do_read) begin
            level_d = level_q + LVL_W'(1);
        end else if (!do_write && do_read) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge s_axi_aclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            level_q <= level_d;
            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_read) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (overflow_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = (level_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_level    = level_q;
    assign overflow      = overflow_q;
    assign frame_err     = frame_err_q;

endmodule
